// File: rtl/hh_pkg.sv
// Shared types and constants for the Hodgkin-Huxley timestep sequencer:
// state encoding, Q8.8 format, default cell constants and saturation helpers.
package hh_pkg;

   localparam int Q_WIDTH = 16;
   localparam int Q_FRAC  = 8;

   localparam logic signed [15:0] SAT16_MAX = 16'sh7FFF;
   localparam logic signed [15:0] SAT16_MIN = 16'sh8000;
   localparam logic signed [17:0] SAT18_MAX = 18'sd32767;
   localparam logic signed [17:0] SAT18_MIN = -18'sd32768;

   // Default squid-axon constants in Q8.8, potentials relative to rest
   localparam logic signed [15:0] GK_DEF   = 16'sd9216;
   localparam logic signed [15:0] GNA_DEF  = 16'sd30720;
   localparam logic signed [15:0] GL_DEF   = 16'sd77;
   localparam logic signed [15:0] EK_DEF   = -16'sd3072;
   localparam logic signed [15:0] ENA_DEF  = 16'sd29440;
   localparam logic signed [15:0] EL_DEF   = 16'sd2714;
   localparam logic signed [15:0] DT_C_DEF = 16'sd3;

   typedef enum logic [3:0] {
      IDLE, M1, M2, M3, M4, M5, M6, M7, M8, M9, M10, M11, DONE
   } hh_state_t;

   function automatic logic ovf16(input logic signed [17:0] x);
      return (x > SAT18_MAX) || (x < SAT18_MIN);
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [17:0] x);
      if (x > SAT18_MAX)
         return SAT16_MAX;
      else if (x < SAT18_MIN)
         return SAT16_MIN;
      else
         return x[15:0];
   endfunction

endpackage

// File: rtl/hh_q88_mul.sv
// Combinational signed Q8.8 multiplier: full product, floor shift by the
// fraction bits, then clamp to 16 bits with an overflow flag.
module hh_q88_mul
   import hh_pkg::*;
(
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   output logic signed [15:0] p,
   output logic               ovf
);

   logic signed [31:0] prod;
   logic signed [31:0] shifted;

   assign prod    = 32'(a) * 32'(b);
   assign shifted = prod >>> Q_FRAC;

   always_comb begin
      ovf = 1'b0;
      p   = shifted[15:0];
      if (shifted > 32'sd32767) begin
         ovf = 1'b1;
         p   = SAT16_MAX;
      end else if (shifted < -32'sd32768) begin
         ovf = 1'b1;
         p   = SAT16_MIN;
      end
   end

endmodule

// File: rtl/hh_step_sequencer.sv
// Per-timestep HH scheduler: eleven micro-ops through one shared Q8.8
// multiplier. Optional macro HH_OVERRUN_CNT_EN adds a dropped-start counter.
module hh_step_sequencer
   import hh_pkg::*;
#(
   parameter logic signed [15:0] GK   = GK_DEF,
   parameter logic signed [15:0] GNA  = GNA_DEF,
   parameter logic signed [15:0] GL   = GL_DEF,
   parameter logic signed [15:0] EK   = EK_DEF,
   parameter logic signed [15:0] ENA  = ENA_DEF,
   parameter logic signed [15:0] EL   = EL_DEF,
   parameter logic signed [15:0] DT_C = DT_C_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [15:0] V_in,
   input  logic signed [15:0] n_in,
   input  logic signed [15:0] m_in,
   input  logic signed [15:0] h_in,
   input  logic signed [15:0] I_ext,
   output logic               busy,
   output logic               done,
   output logic signed [15:0] I_K,
   output logic signed [15:0] I_Na,
   output logic signed [15:0] I_L,
   output logic signed [15:0] V_next,
   output logic               sat
`ifdef HH_OVERRUN_CNT_EN
   ,output logic [7:0]        overrun_cnt
`endif
);

   hh_state_t state;

   logic signed [15:0] v_r, n_r, m_r, h_r, iext_r;
   logic signed [15:0] t_r, ik_r, ina_r, il_r, vn_r;
   logic               sat_acc;

   logic signed [15:0] mul_a, mul_b, mul_p, e_sel;
   logic               mul_ovf, step_ovf;
   logic signed [17:0] diff, isum, vsum;

   hh_q88_mul u_mul (
      .a   (mul_a),
      .b   (mul_b),
      .p   (mul_p),
      .ovf (mul_ovf)
   );

   assign diff = 18'(v_r) - 18'(e_sel);
   assign isum = 18'(iext_r) - 18'(ik_r) - 18'(ina_r) - 18'(il_r);
   assign vsum = 18'(v_r) + 18'(mul_p);

   // Operand steering for the shared multiplier, plus this cycle's saturation events
   always_comb begin
      mul_a    = '0;
      mul_b    = '0;
      e_sel    = EL;
      step_ovf = mul_ovf;
      case (state)
         M1:  begin mul_a = n_r;  mul_b = n_r;  end
         M2:  begin mul_a = t_r;  mul_b = t_r;  end
         M3:  begin mul_a = t_r;  mul_b = GK;   end
         M4:  begin e_sel = EK;  mul_a = t_r; mul_b = sat16(diff); step_ovf = mul_ovf | ovf16(diff); end
         M5:  begin mul_a = m_r;  mul_b = m_r;  end
         M6:  begin mul_a = t_r;  mul_b = m_r;  end
         M7:  begin mul_a = t_r;  mul_b = h_r;  end
         M8:  begin mul_a = t_r;  mul_b = GNA;  end
         M9:  begin e_sel = ENA; mul_a = t_r; mul_b = sat16(diff); step_ovf = mul_ovf | ovf16(diff); end
         M10: begin e_sel = EL;  mul_a = GL;  mul_b = sat16(diff); step_ovf = mul_ovf | ovf16(diff); end
         M11: begin
            mul_a    = DT_C;
            mul_b    = sat16(isum);
            step_ovf = mul_ovf | ovf16(isum) | ovf16(vsum);
         end
         default: ;
      endcase
   end

   // Sequencer FSM; results are published only in DONE so outputs hold between steps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         sat     <= 1'b0;
         I_K     <= '0;
         I_Na    <= '0;
         I_L     <= '0;
         V_next  <= '0;
         v_r     <= '0;
         n_r     <= '0;
         m_r     <= '0;
         h_r     <= '0;
         iext_r  <= '0;
         t_r     <= '0;
         ik_r    <= '0;
         ina_r   <= '0;
         il_r    <= '0;
         vn_r    <= '0;
         sat_acc <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && state != DONE)
            sat_acc <= sat_acc | step_ovf;
         case (state)
            IDLE: begin
               if (start) begin
                  v_r     <= V_in;
                  n_r     <= n_in;
                  m_r     <= m_in;
                  h_r     <= h_in;
                  iext_r  <= I_ext;
                  sat_acc <= 1'b0;
                  busy    <= 1'b1;
                  state   <= M1;
               end
            end
            M1:  begin t_r   <= mul_p; state <= M2;  end
            M2:  begin t_r   <= mul_p; state <= M3;  end
            M3:  begin t_r   <= mul_p; state <= M4;  end
            M4:  begin ik_r  <= mul_p; state <= M5;  end
            M5:  begin t_r   <= mul_p; state <= M6;  end
            M6:  begin t_r   <= mul_p; state <= M7;  end
            M7:  begin t_r   <= mul_p; state <= M8;  end
            M8:  begin t_r   <= mul_p; state <= M9;  end
            M9:  begin ina_r <= mul_p; state <= M10; end
            M10: begin il_r  <= mul_p; state <= M11; end
            M11: begin vn_r  <= sat16(vsum); state <= DONE; end
            DONE: begin
               I_K    <= ik_r;
               I_Na   <= ina_r;
               I_L    <= il_r;
               V_next <= vn_r;
               sat    <= sat_acc;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HH_OVERRUN_CNT_EN
   // Counts cycles where a start arrived while a step was in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overrun_cnt <= '0;
      else if (start && busy && overrun_cnt != 8'hFF)
         overrun_cnt <= overrun_cnt + 8'd1;
   end
`endif

endmodule

// File: doc/hh_step_sequencer.md
Name: hh_step_sequencer

Overview:
- Per-timestep scheduler for the Hodgkin-Huxley neuron datapath.
- On each `start` tick it time-multiplexes one shared signed Q8.8 multiplier to compute I_K = gK·n⁴·(V−EK), I_Na = gNa·m³·h·(V−ENa) and I_L = gL·(V−EL).
- It then integrates V_next = V + DT_C·(I_ext − I_K − I_Na − I_L).
- It sits between the gating-variable updaters (n, m, h) and the membrane-potential register, replacing per-current wide multipliers.

Parameters:
- GK, 16'sd9216, K conductance, Q8.8 (36.0)
- GNA, 16'sd30720, Na conductance, Q8.8 (120.0)
- GL, 16'sd77, leak conductance, Q8.8 (~0.3)
- EK, -16'sd3072, K reversal, Q8.8 (−12.0, rest-relative)
- ENA, 16'sd29440, Na reversal, Q8.8 (115.0)
- EL, 16'sd2714, leak reversal, Q8.8 (~10.6)
- DT_C, 16'sd3, dt/C_m, Q8.8

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  timestep request; accepted only in IDLE
- V_in  in  16  signed Q8.8 membrane potential
- n_in  in  16  signed Q8.8 K activation
- m_in  in  16  signed Q8.8 Na activation
- h_in  in  16  signed Q8.8 Na inactivation
- I_ext  in  16  signed Q8.8 injected current
- busy  out  1  high from the accept edge until the done cycle
- done  out  1  one-cycle pulse; result outputs updated in the same cycle
- I_K  out  16  signed Q8.8 potassium current
- I_Na  out  16  signed Q8.8 sodium current
- I_L  out  16  signed Q8.8 leak current
- V_next  out  16  signed Q8.8 updated potential
- sat  out  1  set if any operation in the last step saturated; updated with done

Behaviour:
- Reset (rst=1, asynchronous):
  - State goes to IDLE.
  - busy, done, sat, I_K, I_Na, I_L and V_next all go to 0.
  - Internal temporaries are cleared.
- Operand capture:
  - With start=1 in IDLE at edge k, V, n, m, h and I_ext are latched and busy=1.
  - Input changes after edge k do not affect the step.
- States: IDLE, then M1..M11 (one multiply per state), then DONE, then IDLE. Each transition is unconditional.
- Micro-ops (t is a temporary, d is a differenced operand):
  - M1: t = n·n
  - M2: t = t·t
  - M3: t = t·GK
  - M4: iK = t·(V−EK)
  - M5: t = m·m
  - M6: t = t·m
  - M7: t = t·h
  - M8: t = t·GNA
  - M9: iNa = t·(V−ENA)
  - M10: iL = GL·(V−EL)
  - M11: vn = V + DT_C·(I_ext − iK − iNa − iL)
- Latency: DONE occupies edge k+12.
  - At that edge: done=1 for one cycle; I_K, I_Na, I_L, V_next and sat register from the temporaries; busy=0.
  - A new start is accepted at edge k+13 at the earliest.
- Multiply rule:
  - Form the 32-bit signed product, then arithmetic shift right by 8 (floor).
  - Saturate to [−32768, 32767].
- Add/subtract rule:
  - Differences (V−E*) and the I_ext − … sum use 18-bit intermediates, saturated to 16 bits before entering the multiplier or the final add.
  - The final V add also saturates.
- sat is the OR of every saturation event in that step; it is cleared at accept.
- start while busy (M1..DONE) is ignored. No queuing; the step in flight is unaffected.
- Outputs hold their values between done pulses.
- Reset mid-step aborts the step: no done pulse, and outputs return to 0.

Optional Feature:
- Macro: HH_OVERRUN_CNT_EN.
- When defined:
  - Adds output `overrun_cnt` [7:0].
  - The counter increments, saturating at 255, for each cycle with start=1 while busy=1.
  - Reset clears it to 0.
- When undefined: the port and counter are absent, and dropped starts are silent.

Decomposition:
- Package hh_pkg holds:
  - state enum (IDLE, M1..M11, DONE)
  - Q8.8 width and fraction-bit localparams
  - default conductance and reversal constants
  - SAT16 min/max constants
- Sub-module hh_q88_mul: combinational signed 16×16 multiply, >>>8, saturate, with a sat flag output. It is the single shared multiplier instance.
- The sequencer muxes its operands by state.

Test Plan:
- Leak only: V=0, n=m=h=0, I_ext=0, start → done at k+12. Expect I_K=0, I_Na=0, I_L=−817, V_next=9, sat=0.
- K saturation: V=0, n=256, m=h=0, I_ext=0 → I_K=32767, sat=1.
- K null: V=−3072, n=256, m=h=0 → I_K=0 exactly.
- Busy ignore: start at k, then start held high through k+12 → exactly one done, at k+12. With HH_OVERRUN_CNT_EN, expect overrun_cnt=12.
- Reset mid-step: start, then rst pulse during M5 → busy=0 and all outputs 0 immediately; no done for 20 cycles. A following start produces a normal result at +12.
- Back-to-back: start at k and again at k+13 with V changed to 256 → second result uses the new V; the first result holds until the second done.
